uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter, successor to the fixed 8-bit serializer/parity/FSM/mux transmitter in the UART path of the multi-clock communication system. It adds a configurable data width, an input word FIFO with a valid/ready handshake, a runtime-selectable one or two stop bits, and an optional internal baud prescaler. It sits between the system controller's TX data path and the `TX_OUT` pad. It runs in the UART clock domain.

## Interface
- DATA_WIDTH, 8: data bits per frame, 5..9.
- FIFO_DEPTH, 4: input buffer depth in words; a power of two, ≥2.
- PRESC_W, 6: width of PRESCALE. Only used with UART_TX_PRESCALE_EN.

- CLK  in  1  UART-domain clock. This is the single clock.
- RST  in  1  asynchronous, active-high reset.
- P_DATA  in  DATA_WIDTH  word to transmit, sent LSB first.
- DATA_VALID  in  1  P_DATA is valid.
- DATA_READY  out  1  FIFO can accept a word. Equals !full.
- PAR_EN  in  1  1 = append a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  1 = two stop bits, 0 = one stop bit.
- PRESCALE  in  PRESC_W  CLK cycles per bit. Present only with UART_TX_PRESCALE_EN.
- S_DATA  out  1  serial line, registered. Idles high.
- busy  out  1  high while a frame is on the line.

## Operation
- **Handshake**
  - A word is pushed on every CLK edge with DATA_VALID && DATA_READY.
  - DATA_VALID while DATA_READY=0 is ignored; the word is not stored.
  - DATA_READY depends only on the registered fill level. There is no pass-through from pop to push.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. The word is popped on that edge.
  - At the same edge, PAR_EN, PAR_TYP and STOP2 are latched, and the parity bit is computed from the popped word.
  - Mid-frame changes to PAR_EN, PAR_TYP or STOP2 affect only the next frame.
- **Bits on the line:**
  - START drives 0.
  - DATA drives bits 0..DATA_WIDTH-1.
  - PARITY is entered only if the latched PAR_EN=1. Even parity: the parity bit makes the total count of 1s even. Odd parity: it makes the count odd.
  - STOP drives 1 for one or two bit periods.
- **End of STOP:** if the FIFO is non-empty, pop and go directly to START with no idle bit. Otherwise go to IDLE.
- **busy** is 1 in every state except IDLE. It stays 1 across back-to-back frames.
- **Reset** (at any time, including mid-frame):
  - S_DATA=1, busy=0, DATA_READY=1.
  - FIFO is emptied, FSM goes to IDLE, bit and prescale counters clear.
  - A partially sent frame is abandoned.
- **Simultaneous push and pop** in one cycle: the fill level is unchanged. Pop happens only when the registered count is greater than 0.

## Timing
- One bit period:
  - With the macro: PRESCALE CLK cycles. PRESCALE=0 is treated as 1.
  - Without the macro: 1 CLK cycle.
- Latency: a word pushed into an empty FIFO at edge N gives a start bit on S_DATA from edge N+1. busy rises at N+1.
- Frame length = 1 + DATA_WIDTH + PAR_EN + (STOP2 ? 2 : 1) bit periods.
- After the last stop bit:
  - If the FIFO is empty, S_DATA stays 1 and busy falls at the same edge the FSM enters IDLE.
  - If the FIFO is non-empty, the next start bit begins at that edge.
- DATA_READY falls on the edge that makes the FIFO hold FIFO_DEPTH words. It rises on the next pop.

## Configuration
- **UART_TX_PRESCALE_EN**
  - Defined: the PRESCALE port and a PRESC_W-bit baud counter are compiled in. Each FSM state advances once per PRESCALE cycles. PRESCALE is sampled at the start of each bit.
  - Not defined: the PRESCALE port and the counter are absent. One bit is sent per CLK, and CLK must already run at the baud rate.

## Structure
- **Package `uart_tx_pkg`:**
  - FSM state enum.
  - Constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
  - Helper function returning the parity bit for a word and a type.
- **Sub-module `uart_tx_fifo`:** synchronous FIFO parametrised by width and depth. It provides full, empty and count.
- FSM, shift register, parity and output register live in uart_tx_param.

## Test plan
- **Basic frame:** DATA_WIDTH=8, no macro, PAR_EN=0, STOP2=0; push 0xA5. S_DATA = 0,1,0,1,0,0,1,0,1,1. busy is high for exactly 10 cycles.
- **Parity:** push 0xA5 with PAR_EN=1, PAR_TYP=0, then again with PAR_TYP=1. The parity bit is 0 for even and 1 for odd. The frame is 11 bits.
- **Two stop bits, back-to-back:** STOP2=1; push 0x00 then 0xFF without a gap. The line shows 2 stop highs, then the next start bit immediately. busy never drops between frames.
- **Full FIFO:** FIFO_DEPTH=4; hold DATA_VALID high with words 1..6. Words 1..5 are accepted: one pops into the FSM and four are buffered. DATA_READY goes low and word 6 is accepted only after the next pop. All accepted words are sent in order.
- **Prescale (macro defined):** PRESCALE=16; push 0x3C. Each bit is held 16 CLK cycles. The frame takes 160 cycles.
- **Reset mid-frame:** assert RST during the DATA state. S_DATA=1, busy=0 and DATA_READY=1 immediately. Buffered words are discarded. A push after reset starts a clean frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types for the parametrised UART transmitter: the frame FSM state,
// the line levels and the parity helper.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Widest supported data word; narrower words are zero-extended before the parity fold.
  localparam int MAX_DW = 9;

  function automatic logic parity_bit(input logic [MAX_DW-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO in front of the transmitter FSM. DEPTH must be a power of two,
// so the read and write pointers wrap without extra compare logic.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: a word is only ever read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: word FIFO, frame FSM, parity and registered line driver.
// Define UART_TX_PRESCALE_EN to add the PRESCALE port and the per-bit baud counter.
module uart_tx_param
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_PRESCALE_EN
  input  logic [PRESC_W-1:0]    PRESCALE,
`endif
  output logic                  S_DATA,
  output logic                  busy
);

  localparam int BCW = $clog2(DATA_WIDTH);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_q, bit_d;
  logic                  par_en_q, par_en_d;
  logic                  par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  s_data_q, s_data_d;
  logic                  start_frame, pop, tick;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  uart_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (DATA_VALID),
    .wdata_i (P_DATA),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o ()
  );

  assign DATA_READY = !fifo_full;
  assign S_DATA     = s_data_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef UART_TX_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q, presc_d, presc_load;

  // Down-counter reloaded at every bit boundary; parked at zero while idle so IDLE reacts at once.
  assign presc_load = (PRESCALE == '0) ? '0 : PRESCALE - PRESC_W'(1);
  assign tick       = (presc_q == '0);

  always_comb begin
    presc_d = presc_q - PRESC_W'(1);
    if (tick) presc_d = (state_d == ST_IDLE) ? '0 : presc_load;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) presc_q <= '0;
    else     presc_q <= presc_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    par_en_d    = par_en_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    s_data_d    = s_data_q;
    start_frame = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        s_data_d = IDLE_LEVEL;
        if (!fifo_empty) start_frame = 1'b1;
      end
      ST_START: if (tick) begin
        state_d  = ST_DATA;
        bit_d    = '0;
        s_data_d = shift_q[0];
      end
      ST_DATA: if (tick) begin
        if (bit_q == BCW'(DATA_WIDTH - 1)) begin
          bit_d = '0;
          if (par_en_q) begin
            state_d  = ST_PARITY;
            s_data_d = par_q;
          end else begin
            state_d  = ST_STOP;
            s_data_d = STOP_BIT;
          end
        end else begin
          bit_d    = bit_q + BCW'(1);
          shift_d  = shift_q >> 1;
          s_data_d = shift_q[1];
        end
      end
      ST_PARITY: if (tick) begin
        state_d  = ST_STOP;
        s_data_d = STOP_BIT;
      end
      ST_STOP: if (tick) begin
        // bit_q counts stop bits already sent; the second one only with a latched STOP2.
        if (stop2_q && bit_q == '0) begin
          bit_d = BCW'(1);
        end else if (!fifo_empty) begin
          start_frame = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          s_data_d = IDLE_LEVEL;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      pop      = 1'b1;
      state_d  = ST_START;
      bit_d    = '0;
      shift_d  = fifo_rdata;
      par_en_d = PAR_EN;
      par_d    = parity_bit(MAX_DW'(fifo_rdata), PAR_TYP);
      stop2_d  = STOP2;
      s_data_d = START_BIT;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      s_data_q <= IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      s_data_q <= s_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: a queue-based line model checked every cycle, plus literal frames.
// Works with or without UART_TX_PRESCALE_EN defined.
module tb_uart_tx_param;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          DATA_READY;
  logic          PAR_EN, PAR_TYP, STOP2;
  logic          S_DATA, busy;
`ifdef UART_TX_PRESCALE_EN
  logic [PW-1:0] PRESCALE = PW'(1);
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  always #5 CLK = ~CLK;

  uart_tx_param #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .PRESC_W    (PW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
`ifdef UART_TX_PRESCALE_EN
    .PRESCALE   (PRESCALE),
`endif
    .S_DATA     (S_DATA),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_fifo[$];
  bit            m_line[$];   // head = value S_DATA must show this cycle

  function automatic int period();
`ifdef UART_TX_PRESCALE_EN
    return (PRESCALE == 0) ? 1 : int'(PRESCALE);
`else
    return 1;
`endif
  endfunction

  task automatic add_frame(input logic [DW-1:0] w, input bit pe, input bit pt, input bit s2);
    bit fb[$];
    int ones, p;
    ones = $countones(w);
    p    = period();
    fb.push_back(1'b0);
    for (int i = 0; i < DW; i++) fb.push_back(w[i]);
    if (pe) fb.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    fb.push_back(1'b1);
    if (s2) fb.push_back(1'b1);
    foreach (fb[i]) repeat (p) m_line.push_back(fb[i]);
  endtask

  int            mdl_pre_n;
  bit            mdl_acc, mdl_bit;
  logic [DW-1:0] mdl_w;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_fifo.delete();
      m_line.delete();
    end else begin
      mdl_pre_n = m_fifo.size();
      mdl_acc   = DATA_VALID && (mdl_pre_n < DEPTH);
      if (m_line.size() > 0) mdl_bit = m_line.pop_front();
      if (m_line.size() == 0 && mdl_pre_n > 0) begin
        mdl_w = m_fifo.pop_front();
        add_frame(mdl_w, PAR_EN, PAR_TYP, STOP2);
      end
      if (mdl_acc) m_fifo.push_back(P_DATA);
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("model s_data", S_DATA, (m_line.size() > 0) ? m_line[0] : 1'b1);
      chk("model busy", busy, m_line.size() > 0);
      chk("model ready", DATA_READY, m_fifo.size() < DEPTH);
    end
  end

  // ---------------- stimulus helpers (called at a negedge, return at a negedge) ----------------
  int cap[$];

  task automatic push(input logic [DW-1:0] w);
    bit done;
    done       = 1'b0;
    P_DATA     = w;
    DATA_VALID = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      done = DATA_READY;
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    chk("push accepted", done, 1);
  endtask

  task automatic capture(input int nwin, output int nbusy, output int runs);
    bit prev;
    prev  = 1'b0;
    nbusy = 0;
    runs  = 0;
    cap.delete();
    for (int i = 0; i < nwin; i++) begin
      if (busy) begin
        cap.push_back(int'(S_DATA));
        nbusy++;
        if (!prev) runs++;
      end
      prev = busy;
      @(negedge CLK);
    end
  endtask

  task automatic check_frame(input string name, input int nb, input int runs,
                             input string s, input int per);
    int len;
    len = s.len() * per;
    chk({name, " length"}, nb, len);
    chk({name, " busy runs"}, runs, 1);
    for (int i = 0; i < len; i++)
      if (i < cap.size())
        chk($sformatf("%s bit%0d", name, i), cap[i], (s[i / per] == "1") ? 1 : 0);
  endtask

  // ---------------- test sequence ----------------
  int nb, runs;

  initial begin
    DATA_VALID = 1'b0;
    P_DATA     = '0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    STOP2      = 1'b0;
    RST        = 1'b1;
    repeat (2) @(negedge CLK);
    chk_on = 1'b1;
    chk("reset s_data", S_DATA, 1);
    chk("reset busy", busy, 0);
    chk("reset ready", DATA_READY, 1);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // basic frame
    push(8'hA5);
    capture(14, nb, runs);
    check_frame("basic", nb, runs, "0101001011", 1);

    // parity even / odd
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    push(8'hA5);
    capture(15, nb, runs);
    check_frame("par_even", nb, runs, "01010010101", 1);
    PAR_TYP = 1'b1;
    push(8'hA5);
    capture(15, nb, runs);
    check_frame("par_odd", nb, runs, "01010010111", 1);
    PAR_EN = 1'b0; PAR_TYP = 1'b0;

    // two stop bits, back to back
    STOP2 = 1'b1;
    push(8'h00);
    push(8'hFF);
    capture(26, nb, runs);
    check_frame("stop2_b2b", nb, runs, "0000000001101111111111", 1);
    STOP2 = 1'b0;

    // full FIFO
    for (int w = 1; w <= 5; w++) push(DW'(w));
    chk("full ready low", DATA_READY, 0);
    push(8'd6);
    repeat (80) @(negedge CLK);
    chk("full drained busy", busy, 0);

`ifdef UART_TX_PRESCALE_EN
    PRESCALE = PW'(16);
    push(8'h3C);
    capture(175, nb, runs);
    check_frame("prescale16", nb, runs, "0001111001", 16);
    PRESCALE = PW'(1);
`endif

    // reset mid-frame
    push(8'h11);
    push(8'h22);
    push(8'h33);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midrst s_data", S_DATA, 1);
    chk("midrst busy", busy, 0);
    chk("midrst ready", DATA_READY, 1);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    capture(14, nb, runs);
    chk("midrst discarded", nb, 0);
    push(8'h5A);
    capture(14, nb, runs);
    check_frame("after_rst", nb, runs, "0010110101", 1);

    // randomized traffic with configuration changing at any cycle
`ifdef UART_TX_PRESCALE_EN
    PRESCALE = PW'(3);
`endif
    for (int c = 0; c < 3000; c++) begin
      DATA_VALID = ($urandom_range(0, 3) == 0);
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      STOP2      = 1'($urandom);
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    repeat (400) @(negedge CLK);
    chk("final idle busy", busy, 0);
    chk("final idle ready", DATA_READY, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
